seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised Moore serial pattern detector. It is the configurable successor to the fixed 3-bit "101" detector and is used wherever a serial control or framing line must be scanned for a sync word. Pattern width, pattern value and match-counter width are parameters. Overlapping versus non-overlapping detection is selectable at run time. The block adds a clock enable and a saturating match counter with synchronous clear.

## Interface

Parameters:
- `PAT_W`, default 3: pattern length in bits. Legal range is 1..16.
- `PATTERN`, default 3'b101: the pattern to detect. `PATTERN[PAT_W-1]` is the first bit received.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`  input  1: the single clock. All state updates on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `en`  input  1: sample enable. `in` is consumed only on an edge where `en`=1.
- `in`  input  1: serial data bit.
- `overlap`  input  1: 1 selects overlapping detection, 0 selects non-overlapping. Sampled on every enabled edge.
- `count_clr`  input  1: synchronous clear of `match_count`.
- `out`  output  1: Moore match flag. High while the FSM is in state PAT_W.
- `match_count`  output  CNT_W: number of matches seen, saturating.

## Operation

- The FSM state `s` ranges over 0..PAT_W and is held in `SW = $clog2(PAT_W+1)` bits. `s` is the length of the longest pattern prefix that is also a suffix of the bits consumed so far.
- Next-state function `delta(s, b)` is the standard prefix-automaton (KMP) transition:
  - If s<PAT_W and b equals pattern bit s, the next state is s+1.
  - Otherwise, the next state is the longest proper prefix that is a suffix of (matched prefix followed by b).
  - The table is computed at elaboration time, so no runtime search is performed.
- Transitions on an enabled edge:
  - From s<PAT_W: next state is `delta(s, in)`.
  - From s=PAT_W with `overlap`=1: next state is `delta(PAT_W, in)`.
  - From s=PAT_W with `overlap`=0: next state is `delta(0, in)`, i.e. the search restarts from scratch.
- With the default parameters and `overlap`=1, state and output behaviour is identical to the legacy 101 detector: 0→(1)→1, 1→(0)→2, 2→(1)→3, 2→(0)→0, 3→(1)→1, 3→(0)→2.
- When `en`=0: `s`, `out` and `match_count` hold. `overlap` and `in` are ignored.
- `out` = (s == PAT_W). It is decoded directly from the state register, with no input-to-output combinational path.
- `match_count` increments by 1 on each enabled edge where the next state is PAT_W.
  - It saturates at 2^CNT_W−1 and never wraps.
- Simultaneous `count_clr` and an increment: the clear wins and `match_count` becomes 0; that match is not counted.
- `count_clr` is effective regardless of `en`. It does not affect `s`.
- Any state encoding outside 0..PAT_W returns to 0 on the next edge, regardless of `en`.

## Timing

- Reset values: `s`=0, `out`=0, `match_count`=0.
- `reset` overrides `en` and `count_clr`. Asserting it mid-pattern discards partial progress at the next edge.
- Latency: the last pattern bit is sampled at edge k. `out` and the updated `match_count` are visible after edge k, i.e. during cycle k+1.
- `out` stays high for exactly one enabled cycle per match.
  - It is high longer if `en` drops while in state PAT_W.
  - It is high on consecutive cycles for self-overlapping patterns, e.g. 111 fed 1111 with `overlap`=1.
- A change of `overlap` takes effect on the first enabled edge on which it is sampled.

## Structure

- Package `seq_det_pkg` contains:
  - the elaboration-time function `next_state(pattern, pat_w, s, b)`;
  - the `SW` width helper;
  - a localparam table generated from `next_state` for both input values.
- Sub-module `seq_sat_counter` is a CNT_W-bit saturating counter with inputs `inc` and `clr`, where clr has priority.
- The top level contains the state register, the overlap mux on the PAT_W transition, and the `out` decode.

## Test plan

- Defaults, `overlap`=1, `en`=1, stream 1,0,1,0,1 → `out` high after edges 3 and 5 only; `match_count`=2.
- Defaults, `overlap`=0, same stream 1,0,1,0,1 → `out` high after edge 3 only; `match_count`=1; state 1 after edge 5.
- `PAT_W`=4, `PATTERN`=4'b1101, `overlap`=1, stream 1,1,0,1,1,0,1 → `out` high after edges 4 and 7; `match_count`=2.
- Defaults, stream 1,0 then `en`=0 for 3 cycles with `in`=0, then `en`=1 with `in`=1 → `out` high after the enabling edge, proving hold during `en`=0.
- `CNT_W`=2, `PATTERN`=3'b111, `overlap`=1, stream of six 1s → `out` high after edges 3..6; `match_count` reaches 3 and stays 3. Then `count_clr` together with a further match → `match_count`=0.
- Defaults, stream 1,0 then `reset`=1 with `in`=1, then stream 1 → `out`=0 and state 1 afterwards. Reset values of all outputs are checked after the first edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and elaboration-time prefix-automaton table builder
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;

  typedef logic [4:0]                 st_t;
  typedef st_t [1:0]                  tbl_row_t;
  typedef tbl_row_t [MAX_PAT_W:0]     nstate_tbl_t;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Bit i in arrival order (i = 0 is the first bit) of an msb-first pattern.
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern, input int pat_w, input int i);
    logic [MAX_PAT_W-1:0] sh;
    sh = pattern >> (pat_w - 1 - i);
    return sh[0];
  endfunction

  function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern, input int pat_w,
                                    input int s, input logic b);
    int   best;
    logic ok;
    logic c;
    best = 0;
    if (s < pat_w && b == pat_bit(pattern, pat_w, s)) begin
      best = s + 1;
    end else begin
      // Candidate string is pattern[0..s-1] followed by b; keep the longest prefix/suffix hit.
      for (int k = 1; k <= MAX_PAT_W; k++) begin
        if (k <= s) begin
          ok = 1'b1;
          for (int j = 0; j < MAX_PAT_W; j++) begin
            if (j < k) begin
              c = (s + 1 - k + j == s) ? b : pat_bit(pattern, pat_w, s + 1 - k + j);
              if (c != pat_bit(pattern, pat_w, j)) begin
                ok = 1'b0;
              end
            end
          end
          if (ok) begin
            best = k;
          end
        end
      end
    end
    return best;
  endfunction

  function automatic nstate_tbl_t build_table(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
    nstate_tbl_t t;
    t = '0;
    for (int s = 0; s <= MAX_PAT_W; s++) begin
      if (s <= pat_w) begin
        t[s][0] = st_t'(next_state(pattern, pat_w, s, 1'b0));
        t[s][1] = st_t'(next_state(pattern, pat_w, s, 1'b1));
      end
    end
    return t;
  endfunction

  localparam nstate_tbl_t LEGACY_101_TBL = build_table(16'b101, 3);

endpackage

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - saturating event counter with priority synchronous clear
module seq_sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && r_count != CNT_MAX) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore serial pattern detector with match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int          SW  = state_w(PAT_W);
  localparam nstate_tbl_t TBL = build_table(MAX_PAT_W'(PATTERN), PAT_W);

  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

  logic [SW-1:0] r_s;
  logic [SW-1:0] w_row;
  logic [4:0]    w_idx;
  logic [SW-1:0] w_next;
  logic          w_valid;
  logic          w_inc;

  // Non-overlapping mode restarts the search from row 0 once a match is reached.
  always_comb begin
    w_valid = (r_s <= S_MATCH);
    w_row   = r_s;
    if (!w_valid || (r_s == S_MATCH && !overlap)) begin
      w_row = S_IDLE;
    end
    w_idx  = 5'(w_row);
    w_next = TBL[w_idx][in][SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= S_IDLE;
    end else if (!w_valid) begin
      r_s <= S_IDLE;
    end else if (en) begin
      r_s <= w_next;
    end
  end

  assign w_inc = en && w_valid && (w_next == S_MATCH);
  assign out   = (r_s == S_MATCH);

  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .clr   (count_clr),
    .count (match_count)
  );

endmodule
